// File: rtl/pipelined_processor_p.sv
// pipelined_processor_p: four-stage (IF, ID, EX, WB) in-order core with
// ADD/SUB/LOAD/STORE/ADDI, hardwired-zero r0, valid/ready instruction intake
// and a retired-instruction counter.
// Build option: define PIPE_FORWARDING_EN to resolve back-to-back dependencies
// by forwarding EX/WB results into EX; otherwise they stall for one cycle.
module pipelined_processor_p #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int RESULT_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] result_out,
    output logic [31:0]       retire_count
);

    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_LOAD  = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_ADDI  = 6'd4;

    // IF/ID
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;

    // ID/EX
    logic              idex_valid_q, idex_valid_d;
    logic [5:0]        idex_op_q, idex_op_d;
    logic [RW-1:0]     idex_rd_q, idex_rd_d;
    logic [DATA_W-1:0] idex_a_q, idex_a_d;
    logic [DATA_W-1:0] idex_b_q, idex_b_d;
    logic [DATA_W-1:0] idex_sdata_q, idex_sdata_d;
    logic [15:0]       idex_imm_q, idex_imm_d;
`ifdef PIPE_FORWARDING_EN
    logic [RW-1:0]     idex_rs1_q, idex_rs1_d;
    logic [RW-1:0]     idex_rs2_q, idex_rs2_d;
`endif

    // EX/WB
    logic              exwb_valid_q, exwb_valid_d;
    logic              exwb_wr_q, exwb_wr_d;
    logic              exwb_load_q, exwb_load_d;
    logic              exwb_store_q, exwb_store_d;
    logic [RW-1:0]     exwb_rd_q, exwb_rd_d;
    logic [DATA_W-1:0] exwb_result_q, exwb_result_d;
    logic [DATA_W-1:0] exwb_sdata_q, exwb_sdata_d;
    logic [MW-1:0]     exwb_idx_q, exwb_idx_d;

    // Architectural state
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] mem_q  [MEM_DEPTH];
    logic [DATA_W-1:0] result_out_q, result_out_d;
    logic [31:0]       retire_q, retire_d;

    // Writeback-side signals shared by the register file, write-through and forwarding
    logic              wb_we;
    logic [DATA_W-1:0] load_data;

    // Decoded fields of the instruction waiting in IF/ID
    logic [5:0]        id_op;
    logic [RW-1:0]     id_rd, id_rs1, id_rs2;
    logic [15:0]       id_imm;

    // EX-stage working values
    logic [DATA_W-1:0] ex_a, ex_b, ex_s, ex_addr, ex_result;

    function automatic logic writes_reg(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) || (op == OP_ADDI);
    endfunction

    // r0 reads as zero; a register being written back this cycle returns the new value
    function automatic logic [DATA_W-1:0] bypass(input logic [RW-1:0]     idx,
                                                 input logic [DATA_W-1:0] raw,
                                                 input logic              we,
                                                 input logic [RW-1:0]     widx,
                                                 input logic [DATA_W-1:0] wdata);
        if (idx == '0) return '0;
        if (we && (widx == idx)) return wdata;
        return raw;
    endfunction

    assign id_op  = ifid_instr_q[31:26];
    assign id_rd  = ifid_instr_q[21 +: RW];
    assign id_rs1 = ifid_instr_q[16 +: RW];
    assign id_rs2 = ifid_instr_q[11 +: RW];
    assign id_imm = ifid_instr_q[15:0];

    assign wb_we     = exwb_valid_q && exwb_wr_q && (exwb_rd_q != '0);
    assign load_data = mem_q[exwb_idx_q];

    assign wb_valid     = wb_we;
    assign wb_rd        = 5'(exwb_rd_q);
    assign wb_data      = exwb_load_q ? load_data : exwb_result_q;
    assign result_out   = result_out_q;
    assign retire_count = retire_q;

`ifdef PIPE_FORWARDING_EN
    assign instr_ready = 1'b1;
`else
    logic hazard;

    // Stall when an ID source depends on the writing instruction one stage ahead in ID/EX
    always_comb begin
        hazard = 1'b0;
        if (ifid_valid_q && idex_valid_q && writes_reg(idex_op_q) && (idex_rd_q != '0)) begin
            if (id_rs1 == idex_rd_q) hazard = 1'b1;
            if (((id_op == OP_ADD) || (id_op == OP_SUB)) && (id_rs2 == idex_rd_q)) hazard = 1'b1;
            if ((id_op == OP_STORE) && (id_rd == idex_rd_q)) hazard = 1'b1;
        end
    end

    assign instr_ready = ~hazard;
`endif

    // IF/ID captures a new instruction (or a bubble) when ready, otherwise holds
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        if (instr_ready) begin
            ifid_valid_d = instr_valid;
            ifid_instr_d = instr_valid ? instr_in : '0;
        end
    end

    // ID reads operands with write-through; a stall pushes a bubble into ID/EX
    always_comb begin
        idex_valid_d = 1'b0;
        idex_op_d    = '0;
        idex_rd_d    = '0;
        idex_a_d     = '0;
        idex_b_d     = '0;
        idex_sdata_d = '0;
        idex_imm_d   = '0;
`ifdef PIPE_FORWARDING_EN
        idex_rs1_d   = '0;
        idex_rs2_d   = '0;
`endif
        if (instr_ready) begin
            idex_valid_d = ifid_valid_q;
            idex_op_d    = id_op;
            idex_rd_d    = id_rd;
            idex_imm_d   = id_imm;
            idex_a_d     = bypass(id_rs1, regs_q[id_rs1], wb_we, exwb_rd_q, wb_data);
            idex_b_d     = bypass(id_rs2, regs_q[id_rs2], wb_we, exwb_rd_q, wb_data);
            idex_sdata_d = bypass(id_rd,  regs_q[id_rd],  wb_we, exwb_rd_q, wb_data);
`ifdef PIPE_FORWARDING_EN
            idex_rs1_d   = id_rs1;
            idex_rs2_d   = id_rs2;
`endif
        end
    end

    // EX computes the ALU result, memory word index and store data
    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        ex_s = idex_sdata_q;
`ifdef PIPE_FORWARDING_EN
        ex_a = bypass(idex_rs1_q, idex_a_q,     wb_we, exwb_rd_q, wb_data);
        ex_b = bypass(idex_rs2_q, idex_b_q,     wb_we, exwb_rd_q, wb_data);
        ex_s = bypass(idex_rd_q,  idex_sdata_q, wb_we, exwb_rd_q, wb_data);
`endif
        ex_addr = ex_a + DATA_W'(idex_imm_q);
        case (idex_op_q)
            OP_ADD:  ex_result = ex_a + ex_b;
            OP_SUB:  ex_result = ex_a - ex_b;
            default: ex_result = ex_addr;
        endcase
        exwb_valid_d  = idex_valid_q;
        exwb_wr_d     = writes_reg(idex_op_q);
        exwb_load_d   = (idex_op_q == OP_LOAD);
        exwb_store_d  = (idex_op_q == OP_STORE);
        exwb_rd_d     = idex_rd_q;
        exwb_result_d = ex_result;
        exwb_sdata_d  = ex_s;
        exwb_idx_d    = ex_addr[MW+1:2];
    end

    // Mirror of RESULT_REG and the retire counter, both updated at writeback
    always_comb begin
        result_out_d = regs_q[RESULT_REG];
        if (wb_we && (exwb_rd_q == RW'(RESULT_REG))) result_out_d = wb_data;
        retire_d = retire_q + 32'(exwb_valid_q);
    end

    // Pipeline registers and counters; reset flushes everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= '0;
            idex_valid_q  <= 1'b0;
            idex_op_q     <= '0;
            idex_rd_q     <= '0;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_sdata_q  <= '0;
            idex_imm_q    <= '0;
`ifdef PIPE_FORWARDING_EN
            idex_rs1_q    <= '0;
            idex_rs2_q    <= '0;
`endif
            exwb_valid_q  <= 1'b0;
            exwb_wr_q     <= 1'b0;
            exwb_load_q   <= 1'b0;
            exwb_store_q  <= 1'b0;
            exwb_rd_q     <= '0;
            exwb_result_q <= '0;
            exwb_sdata_q  <= '0;
            exwb_idx_q    <= '0;
            result_out_q  <= '0;
            retire_q      <= '0;
        end else begin
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            idex_valid_q  <= idex_valid_d;
            idex_op_q     <= idex_op_d;
            idex_rd_q     <= idex_rd_d;
            idex_a_q      <= idex_a_d;
            idex_b_q      <= idex_b_d;
            idex_sdata_q  <= idex_sdata_d;
            idex_imm_q    <= idex_imm_d;
`ifdef PIPE_FORWARDING_EN
            idex_rs1_q    <= idex_rs1_d;
            idex_rs2_q    <= idex_rs2_d;
`endif
            exwb_valid_q  <= exwb_valid_d;
            exwb_wr_q     <= exwb_wr_d;
            exwb_load_q   <= exwb_load_d;
            exwb_store_q  <= exwb_store_d;
            exwb_rd_q     <= exwb_rd_d;
            exwb_result_q <= exwb_result_d;
            exwb_sdata_q  <= exwb_sdata_d;
            exwb_idx_q    <= exwb_idx_d;
            result_out_q  <= result_out_d;
            retire_q      <= retire_d;
        end
    end

    // Register file write port; r0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_we) begin
            regs_q[exwb_rd_q] <= wb_data;
        end
    end

    // Data memory write port, driven by a STORE leaving WB
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (exwb_valid_q && exwb_store_q) begin
            mem_q[exwb_idx_q] <= exwb_sdata_q;
        end
    end

endmodule

// File: tb/tb_pipelined_processor_p.sv
// tb_pipelined_processor_p: scoreboard bench for pipelined_processor_p.
// An ISA-level model executes each instruction when it is accepted and queues
// the expected register write; the monitor pops and compares on wb_valid.
`timescale 1ns/1ps
module tb_pipelined_processor_p;

    localparam int PERIOD = 10;

`ifdef PIPE_FORWARDING_EN
    localparam longint DEP_LATENCY = 25;
    localparam int     EXP_STALLS  = 0;
`else
    localparam longint DEP_LATENCY = 35;
    localparam int     EXP_STALLS  = 1;
`endif

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_LOAD  = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_ADDI  = 6'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] result_out;
    logic [31:0] retire_count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        longint      tAccept;
        longint      latency;
    } sbEntry_t;

    sbEntry_t    sbQueue[$];
    sbEntry_t    monEntry;
    logic [31:0] modelRegs [32];
    logic [31:0] modelMem  [1024];
    logic [31:0] modelRetire;
    int          assertCount = 0;
    int          failCount   = 0;
    int          readyLow;

    always #(PERIOD/2) clk = ~clk;

    pipelined_processor_p dut (
        .clk          (clk),
        .reset        (reset),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .result_out   (result_out),
        .retire_count (retire_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mkR(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        for (int i = 0; i < 1024; i++) modelMem[i] = '0;
        modelRetire = '0;
        sbQueue.delete();
    endtask

    // Architectural effect of one instruction, in program order
    task automatic modelExec(input logic [31:0] ins, input longint tAcc, input longint lat);
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, s, addr, res;
        logic        wr;
        op   = ins[31:26];
        rd   = ins[25:21];
        rs1  = ins[20:16];
        rs2  = ins[15:11];
        a    = (rs1 == 0) ? 32'd0 : modelRegs[rs1];
        b    = (rs2 == 0) ? 32'd0 : modelRegs[rs2];
        s    = (rd  == 0) ? 32'd0 : modelRegs[rd];
        addr = a + {16'd0, ins[15:0]};
        res  = '0;
        wr   = 1'b0;
        modelRetire = modelRetire + 1;
        case (op)
            OP_ADD:   begin res = a + b; wr = 1'b1; end
            OP_SUB:   begin res = a - b; wr = 1'b1; end
            OP_LOAD:  begin res = modelMem[addr[11:2]]; wr = 1'b1; end
            OP_STORE: modelMem[addr[11:2]] = s;
            OP_ADDI:  begin res = addr; wr = 1'b1; end
            default:  ;
        endcase
        if (wr && rd != 0) begin
            modelRegs[rd] = res;
            sbQueue.push_back('{rd: rd, data: res, tAccept: tAcc, latency: lat});
        end
    endtask

    // Offer one instruction, holding it while the core is not ready
    task automatic applyStimulus(input logic [31:0] ins, input longint lat);
        int waitCycles;
        waitCycles  = 0;
        instr_in    = ins;
        instr_valid = 1'b1;
        while (!instr_ready && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!instr_ready) begin
            checkOutput("accept_timeout", instr_ready, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        modelExec(ins, $time, lat);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        repeat (5) @(negedge clk);
        checkOutput({tag, "_pending"}, sbQueue.size(), 0);
        checkOutput({tag, "_result_out"}, result_out, modelRegs[1]);
        checkOutput({tag, "_retire"}, retire_count, modelRetire);
    endtask

    // Scoreboard monitor: every register write must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_wb", wb_valid, 0);
            end else begin
                monEntry = sbQueue.pop_front();
                checkOutput("wb_rd", wb_rd, monEntry.rd);
                checkOutput("wb_data", wb_data, monEntry.data);
                if (monEntry.latency != 0)
                    checkOutput("wb_latency", $time - monEntry.tAccept, monEntry.latency);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_in    = '0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_ready", instr_ready, 1);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_retire", retire_count, 0);
        checkOutput("rst_result_out", result_out, 0);

        $display("[TB] Test 1: single ADDI");
        applyStimulus(mkI(OP_ADDI, 5'd1, 5'd0, 16'd5), 25);
        @(negedge clk);
        checkOutput("t1_wb_early", wb_valid, 0);
        @(negedge clk);
        checkOutput("t1_result_before_e3", result_out, 0);
        checkOutput("t1_retire_before_e3", retire_count, 0);
        @(negedge clk);
        checkOutput("t1_result_after_e3", result_out, 5);
        checkOutput("t1_retire_after_e3", retire_count, 1);
        drainCheck("t1");

        $display("[TB] Test 2: back-to-back dependency");
        applyStimulus(mkI(OP_ADDI, 5'd2, 5'd0, 16'd7), 25);
        applyStimulus(mkR(OP_ADD, 5'd3, 5'd2, 5'd2), DEP_LATENCY);
        readyLow = 0;
        for (int i = 0; i < 4; i++) begin
            if (!instr_ready) readyLow++;
            @(negedge clk);
        end
        checkOutput("t2_stall_cycles", readyLow, EXP_STALLS);
        drainCheck("t2");

        $display("[TB] Test 3: store/load round trip");
        applyStimulus(mkI(OP_ADDI, 5'd1, 5'd0, 16'd5), 0);
        applyStimulus(mkI(OP_STORE, 5'd1, 5'd0, 16'd8), 0);
        applyStimulus(mkI(OP_LOAD, 5'd4, 5'd0, 16'd8), 0);
        applyStimulus(mkR(OP_ADD, 5'd5, 5'd4, 5'd4), 0);
        applyStimulus(mkI(OP_LOAD, 5'd13, 5'd0, 16'h1008), 0);
        applyStimulus(mkI(OP_LOAD, 5'd14, 5'd0, 16'h000B), 0);
        drainCheck("t3");

        $display("[TB] Test 4: wraparound and zero-extended immediates");
        applyStimulus(mkI(OP_ADDI, 5'd6, 5'd0, 16'd3), 0);
        applyStimulus(mkR(OP_SUB, 5'd7, 5'd0, 5'd6), 0);
        applyStimulus(mkI(OP_ADDI, 5'd8, 5'd0, 16'hFFFF), 0);
        applyStimulus(mkR(OP_ADD, 5'd8, 5'd8, 5'd8), 0);
        applyStimulus(mkR(OP_ADD, 5'd15, 5'd7, 5'd7), 0);
        drainCheck("t4");

        $display("[TB] Test 5: r0 and NOP handling");
        applyStimulus(mkI(OP_ADDI, 5'd0, 5'd0, 16'd9), 0);
        applyStimulus(mkR(OP_ADD, 5'd9, 5'd0, 5'd0), 0);
        applyStimulus(mkI(6'h3F, 5'd1, 5'd2, 16'h1234), 0);
        drainCheck("t5");

        $display("[TB] Test 6: reset flush");
        applyStimulus(mkI(OP_ADDI, 5'd1, 5'd0, 16'h55), 0);
        applyStimulus(mkI(OP_ADDI, 5'd11, 5'd0, 16'h66), 0);
        applyStimulus(mkI(OP_ADDI, 5'd12, 5'd0, 16'h77), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("t6_retire", retire_count, 0);
        checkOutput("t6_result_out", result_out, 0);
        checkOutput("t6_wb_valid", wb_valid, 0);
        checkOutput("t6_ready", instr_ready, 1);
        drainCheck("t6_flush");
        for (int k = 2; k < 16; k++) begin
            applyStimulus(mkR(OP_ADD, 5'd10, 5'(k), 5'd0), 0);
        end
        drainCheck("t6_regs");
        applyStimulus(mkI(OP_ADDI, 5'd1, 5'd0, 16'd2), 25);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_result_before_e3", result_out, 0);
        @(negedge clk);
        checkOutput("t6_result_after_e3", result_out, 2);
        drainCheck("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipelined_processor_p.md
Name: pipelined_processor_p

Overview:
- Parametrised successor of the team's 4-stage ADD/SUB/LOAD core, with stages IF, ID, EX and WB.
- Adds data width, register count and memory depth parameters, plus ADDI and STORE.
- Adds a hardwired-zero r0, a valid/ready instruction handshake, hazard handling (forwarding or interlock) and a retired-instruction counter.
- Sits between the instruction source (testbench or fetch unit) and the observation outputs.

Parameters:
- DATA_W, 32, datapath and register width; must be >= 16.
- NUM_REGS, 32, register count; power of two, 2..32. Register index = low log2(NUM_REGS) bits of each 5-bit field.
- MEM_DEPTH, 1024, data memory depth in words; power of two.
- RESULT_REG, 1, register mirrored on result_out.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  32  instruction word.
- instr_valid  in  1  instr_in is valid this cycle.
- instr_ready  out  1  core accepts instr_in this cycle.
- wb_valid  out  1  a register write occurs at the next edge.
- wb_rd  out  5  register index being written (zero-extended).
- wb_data  out  DATA_W  data being written.
- result_out  out  DATA_W  registered copy of register RESULT_REG.
- retire_count  out  32  number of retired non-bubble instructions.

Behaviour:
- Format: opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
- Immediates are zero-extended to DATA_W.
- Opcodes:
  - 000000 ADD: rd = rs1 + rs2.
  - 000001 SUB: rd = rs1 - rs2.
  - 000010 LOAD: rd = mem[idx].
  - 000011 STORE: mem[idx] = rd.
  - 000100 ADDI: rd = rs1 + imm.
  - Any other opcode is a NOP: it retires but writes nothing.
- Memory index: idx = (rs1 + imm)[log2(MEM_DEPTH)+1:2]. The low 2 bits are ignored and the index wraps modulo MEM_DEPTH.
- Arithmetic is modulo 2^DATA_W; there are no flags.
- r0 always reads as 0. Writes to r0 are dropped, and wb_valid stays low for them.
- Each pipeline register carries a valid bit. A bubble has valid=0 and causes no write and no retire.
- Accept occurs when instr_valid && instr_ready. Cycle-level timing, with the accept edge as E0:
  - E0: instruction captured into IF/ID.
  - E1: operands read into ID/EX.
  - E2: ALU result, memory index and store data captured into EX/WB.
  - E2..E3: wb_valid is high for ADD/SUB/LOAD/ADDI with rd != 0.
  - E3: register file written. At the same edge STORE writes memory and retire_count increments.
- LOAD reads memory asynchronously in WB; wb_data is that word.
- result_out updates at edge E3 and takes the write-through value when RESULT_REG is written that cycle.
- Register-file write-through: an ID read of a register being written by WB in the same cycle returns wb_data.
- If instr_valid is low at an edge where instr_ready is high, a bubble enters IF/ID.
- If instr_ready is low, IF/ID holds its contents, a bubble is inserted into ID/EX, and the source must hold instr_in.
- Sources checked for hazards: rs1 for all opcodes; rs2 for ADD/SUB; rd for STORE (store data).
- A source index of 0 never creates a hazard.
- Reset: all valid bits clear and pipeline registers go to 0. Registers, memory, result_out and retire_count clear to 0. instr_ready=1 and wb_valid=0 in the first cycle after reset.
- Reset asserted mid-operation flushes every in-flight instruction with no write and no retire.
- retire_count wraps from 0xFFFFFFFF to 0.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- Defined:
  - EX operands are forwarded from EX/WB when that stage writes a matching rd. LOAD data is forwarded as well.
  - instr_ready is constantly 1 (except never during reset effects); there are no stalls.
- Undefined:
  - If an ID source matches the rd of a valid, writing instruction in ID/EX, instr_ready=0 for exactly one cycle and one bubble is inserted.
  - Distance-2 dependencies are covered by write-through.

Test Plan:
1. Reset; send ADDI r1,r0,5 -> at E2..E3 wb_valid=1, wb_rd=1, wb_data=5; result_out=5 after E3; retire_count=1.
2. Back-to-back ADDI r2,r0,7; ADD r3,r2,r2 -> r3=14. With PIPE_FORWARDING_EN, instr_ready never drops. Without it, instr_ready=0 for exactly one cycle and the ADD retires one cycle later.
3. ADDI r1,r0,5; STORE r1,[r0+8]; LOAD r4,[r0+8]; ADD r5,r4,r4 -> mem[2]=5, r4=5, r5=10 (both builds).
4. ADDI r6,r0,3; SUB r7,r0,r6 -> r7=0xFFFFFFFD (DATA_W=32); ADDI r8,r0,0xFFFF then ADD r8,r8,r8 -> 0x1FFFE.
5. ADDI r0,r0,9; ADD r9,r0,r0 -> wb_valid low for the r0 write; r9=0; opcode 0x3F -> no write, retire_count +1.
6. Issue 3 ADDIs then assert reset for one cycle -> none write, retire_count=0, all registers 0; after release ADDI r1,r0,2 -> result_out=2 at E3.
